router_input_buffer: RTL and testbench
======================================

# router_input_buffer

Per-input-port flit FIFO for the mesh router, sitting directly upstream of the ejector (route computation) stage. It accepts flits from a link or the local core over a valid/ready handshake, stores up to DEPTH flits, and presents the head flit's 6-bit destination address to the ejector's `addr` input. It also presents the payload to the crossbar and pops the head when the switch allocator grants it.

## Interface
- `DATA_W`, 16: payload width in bits.
- `ADDR_W`, 6: destination address width. Bits [5:3] are the row (north/south) and bits [2:0] are the column (east/west), matching the ejector.
- `DEPTH`, 4: FIFO entries. Must be a power of two, ≥2.
- `CNT_W`, $clog2(DEPTH+1): occupancy counter width.

- `clk`  in  1  rising-edge clock, shared with the ejector.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream flit valid.
- `in_ready`  out  1  buffer can accept a flit this cycle.
- `in_flit`  in  ADDR_W+DATA_W  {addr, payload}, with addr in the MSBs.
- `head_valid`  out  1  head entry holds a flit.
- `head_addr`  out  ADDR_W  head flit address; drives the ejector `addr`.
- `head_data`  out  DATA_W  head flit payload, to the crossbar.
- `grant`  in  1  allocator pop of the head flit.
- `count`  out  CNT_W  current occupancy.
- `err`  out  1  sticky protocol error flag.
- `credit_out`  out  1  present only with IBUF_CREDIT_EN.

## Operation
- Storage is a circular buffer with wr_ptr and rd_ptr, each log2(DEPTH) bits wide. Both wrap from DEPTH-1 to 0.
- Occupancy is tracked in `count`. full = (count==DEPTH), empty = (count==0).
- Push occurs when in_valid && in_ready. The flit is written at wr_ptr and wr_ptr increments.
- Pop occurs when grant && head_valid. rd_ptr increments.
- in_ready = !full. It is registered-state derived, with no combinational path from `grant`. A full buffer does not accept a flit in the same cycle it pops one.
- head_valid = !empty. head_addr and head_data equal mem[rd_ptr] and stay stable while head_valid is high and no pop occurs.
- Simultaneous push and pop with 0<count<DEPTH: count is unchanged and both pointers advance.
- Simultaneous push and pop with count==DEPTH: in_ready is low, so only the pop takes effect.
- Push while empty: the flit becomes head the next cycle. There is no bypass.
- grant while empty: ignored, and `err` is set.
- in_valid while full: ignored, with no error. Upstream must hold the flit until in_ready.
- `err` is sticky and clears only on rst.
- Payload and address bits are not interpreted. The address is passed unmodified to the ejector.

## Timing
- Reset, sampled at a rising edge with rst=1, produces:
  - pointers = 0, count = 0, err = 0
  - head_valid = 0, in_ready = 1, credit_out = 0
  - head_addr and head_data are don't-care (the implementation drives mem[0]).
- rst overrides a simultaneous push and pop. Buffer contents are discarded and the reset state holds the next cycle.
- Write-to-head latency is 1 cycle: a flit accepted at edge N has head_valid=1 after edge N.
- Pop latency is 1 cycle: after a grant at edge N, the next entry (or head_valid=0) appears after edge N.
- The ejector is clocked, so its `direct` lags head_addr by one cycle. The allocator must not grant on a head that changed in the same cycle. Keeping this ordering is the allocator's responsibility.
- Throughput is 1 flit per cycle in and out when 0<count<DEPTH.

## Configuration
- Macro: `IBUF_CREDIT_EN`.
- Defined:
  - `credit_out` is a registered 1-cycle pulse, asserted the cycle after each pop.
  - The upstream router initialises its credit counter to DEPTH.
  - 0 after reset.
- Undefined:
  - The `credit_out` port and its logic are absent.
  - Flow control relies on in_ready only.

## Test plan
- Reset, then push 6'b100101 with payload 16'hA001 and hold grant=0 → head_valid=1 and head_addr=6'b100101 the cycle after acceptance, count=1, err=0.
- Push 6'b100001, 6'b110100, 6'b000100 and 6'b100100 back-to-back with grant=0 → count reaches 4 and in_ready=0. A fifth flit 6'b100101 is held off. head_addr stays 6'b100001.
- From full, grant for 4 consecutive cycles → head_addr sequence 100001, 110100, 000100, 100100, then head_valid=0, count=0, in_ready=1 after the first pop.
- With count=2, push and grant in the same cycle for 6 cycles → count holds at 2. Pointers wrap past DEPTH-1, and addresses emerge in push order with no loss or duplication.
- grant=1 while empty → err=1 next cycle, count stays 0, and err persists until rst.
- With IBUF_CREDIT_EN defined, perform 3 pops → exactly 3 single-cycle credit_out pulses, each one cycle after its pop. Asserting rst mid-sequence clears count and suppresses further pulses.

Source files
------------

// File: rtl/router_input_buffer.sv
// Per-input-port flit FIFO feeding the ejector (route computation) and crossbar.
// Optional credit pulse output is enabled by defining IBUF_CREDIT_EN.
module router_input_buffer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W+DATA_W-1:0] in_flit,
  output logic                     head_valid,
  output logic [ADDR_W-1:0]        head_addr,
  output logic [DATA_W-1:0]        head_data,
  input  logic                     grant,
  output logic [CNT_W-1:0]         count,
  output logic                     err
`ifdef IBUF_CREDIT_EN
  ,
  output logic                     credit_out
`endif
);

  localparam int FLIT_W = ADDR_W + DATA_W;
  localparam int PTR_W  = $clog2(DEPTH);

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic              err_q;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  // Handshake: a flit transfers on any edge where in_valid && in_ready; the head
  // leaves on any edge where grant && head_valid. Both ready and valid come from
  // registered occupancy only, so neither side sees a combinational path from the other.
  assign full       = (count_q == CNT_W'(DEPTH));
  assign empty      = (count_q == '0);
  assign in_ready   = !full;
  assign head_valid = !empty;
  assign push       = in_valid && !full;
  assign pop        = grant && !empty;

  assign count     = count_q;
  assign err       = err_q;
  assign head_addr = mem[rd_ptr][FLIT_W-1:DATA_W];
  assign head_data = mem[rd_ptr][DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      // A grant against an empty buffer is an allocator bug; latch it until reset.
      if (grant && empty) err_q <= 1'b1;
    end
  end

  // Storage carries no reset; contents are only observed through head_valid.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= in_flit;
  end

`ifdef IBUF_CREDIT_EN
  always_ff @(posedge clk) begin
    if (rst) credit_out <= 1'b0;
    else     credit_out <= pop;
  end
`endif

endmodule

// File: tb/tb_router_input_buffer.sv
// Bench for router_input_buffer: directed vector table, corner sequences and
// randomized traffic checked against a queue-based model of the buffer.
module tb_router_input_buffer;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int FW     = ADDR_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [FW-1:0]     in_flit = '0;
  logic              head_valid;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              grant = 1'b0;
  logic [CNT_W-1:0]  count;
  logic              err;
`ifdef IBUF_CREDIT_EN
  logic              credit_out;
`endif

  router_input_buffer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_flit(in_flit),
    .head_valid(head_valid), .head_addr(head_addr), .head_data(head_data),
    .grant(grant), .count(count), .err(err)
`ifdef IBUF_CREDIT_EN
    , .credit_out(credit_out)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state: expected contents in arrival order plus sticky flags
  logic [FW-1:0] exp_q[$];
  logic          m_err;
  logic          m_credit;
  int            n_vec  = 0;
  int            n_miss = 0;
  int            credit_pulses = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model, then compare after the edge.
  task automatic step(input logic r, input logic v, input logic g, input logic [FW-1:0] f);
    int  sz;
    logic m_pop, m_push;
    rst = r; in_valid = v; grant = g; in_flit = f;
    sz     = exp_q.size();
    m_pop  = g && (sz > 0);
    m_push = v && (sz < DEPTH);
    if (r) begin
      exp_q.delete();
      m_err    = 1'b0;
      m_credit = 1'b0;
    end else begin
      if (g && sz == 0) m_err = 1'b1;
      m_credit = m_pop;
      if (m_pop)  void'(exp_q.pop_front());
      if (m_push) exp_q.push_back(f);
    end
    @(posedge clk);
    #1;
    chk("head_valid", 32'(head_valid), 32'(exp_q.size() != 0));
    chk("count", 32'(count), 32'(exp_q.size()));
    chk("in_ready", 32'(in_ready), 32'(exp_q.size() < DEPTH));
    chk("err", 32'(err), 32'(m_err));
    if (exp_q.size() != 0) begin
      chk("head_addr", 32'(head_addr), 32'(exp_q[0][FW-1:DATA_W]));
      chk("head_data", 32'(head_data), 32'(exp_q[0][DATA_W-1:0]));
    end
`ifdef IBUF_CREDIT_EN
    chk("credit_out", 32'(credit_out), 32'(m_credit));
    if (credit_out) credit_pulses++;
`endif
  endtask

  function automatic logic [FW-1:0] mk(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    return {a, d};
  endfunction

  typedef struct {
    logic             v;
    logic             g;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic             hv;
    logic [ADDR_W-1:0] ha;
    int               cnt;
    logic             rdy;
    logic             er;
  } vec_t;

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 6'b100101, 16'hA001, 1'b1, 6'b100101, 1, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 6'b000000, 16'h0000, 1'b0, 6'b000000, 0, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 6'b100001, 16'hB001, 1'b1, 6'b100001, 1, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 6'b110100, 16'hB002, 1'b1, 6'b100001, 2, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 6'b000100, 16'hB003, 1'b1, 6'b100001, 3, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 6'b100100, 16'hB004, 1'b1, 6'b100001, 4, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 6'b100101, 16'hB005, 1'b1, 6'b100001, 4, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 6'b000000, 16'h0000, 1'b1, 6'b110100, 3, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 6'b000000, 16'h0000, 1'b1, 6'b000100, 2, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 6'b000000, 16'h0000, 1'b1, 6'b100100, 1, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 6'b000000, 16'h0000, 1'b0, 6'b000000, 0, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 6'b000000, 16'h0000, 1'b0, 6'b000000, 0, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 6'b000000, 16'h0000, 1'b0, 6'b000000, 0, 1'b1, 1'b1};

    m_err = 1'b0;
    m_credit = 1'b0;

    // reset state
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_head_valid", 32'(head_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // directed table: fill, hold off, drain, grant on empty
    for (int i = 0; i < 13; i++) begin
      step(1'b0, tbl[i].v, tbl[i].g, mk(tbl[i].a, tbl[i].d));
      chk($sformatf("tbl%0d_hv", i), 32'(head_valid), 32'(tbl[i].hv));
      chk($sformatf("tbl%0d_cnt", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_rdy", i), 32'(in_ready), 32'(tbl[i].rdy));
      chk($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].er));
      if (tbl[i].hv) chk($sformatf("tbl%0d_addr", i), 32'(head_addr), 32'(tbl[i].ha));
    end
    if (tbl[0].d != 16'hA001) $display("table setup wrong");

    // count=2, simultaneous push and pop for 6 cycles, pointers wrap
    step(1'b1, 1'b0, 1'b0, '0);
    chk("err_cleared_by_rst", 32'(err), 32'd0);
    step(1'b0, 1'b1, 1'b0, mk(6'd1, 16'h1001));
    step(1'b0, 1'b1, 1'b0, mk(6'd2, 16'h1002));
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 1'b1, mk(6'(i + 3), 16'(16'h1003 + i)));
      chk("stream_count", 32'(count), 32'd2);
      chk("stream_addr", 32'(head_addr), 32'(i + 2));
    end
    step(1'b0, 1'b0, 1'b1, '0);
    chk("stream_tail1", 32'(head_addr), 32'd8);
    step(1'b0, 1'b0, 1'b1, '0);
    chk("stream_empty", 32'(head_valid), 32'd0);

    // full: simultaneous valid and grant -> only the pop happens
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, mk(6'(16 + i), 16'(16'h2000 + i)));
    step(1'b0, 1'b1, 1'b1, mk(6'h3f, 16'hDEAD));
    chk("full_pp_count", 32'(count), 32'd3);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, '0);
    chk("full_pp_drained", 32'(count), 32'd0);

    // credit pulses: 3 spaced pops, then reset mid-sequence
    step(1'b1, 1'b0, 1'b0, '0);
    credit_pulses = 0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, mk(6'(40 + i), 16'(16'h3000 + i)));
    step(1'b0, 1'b0, 1'b1, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b1, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b1, '0);
    step(1'b0, 1'b0, 1'b0, '0);
`ifdef IBUF_CREDIT_EN
    chk("credit_pulse_total", 32'(credit_pulses), 32'd3);
`endif
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, mk(6'(48 + i), 16'(16'h3100 + i)));
    step(1'b0, 1'b0, 1'b1, '0);
    step(1'b1, 1'b0, 1'b1, '0);
    chk("rst_mid_count", 32'(count), 32'd0);
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);

    // randomized traffic against the queue model
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) != 0), FW'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
